// File: rtl/stream_transpose_pkg.sv
// -----------------------------------------------------------------------------
// stream_transpose_pkg
//
// Shared definitions for the ping-pong stream transpose block.
//   MODE_TRANSPOSE / MODE_BYPASS : per-matrix read-out mode encoding
//   lane_lsb()                   : bit offset of a lane inside a packed
//                                  N-lane bus (lane i at [i*W +: W])
// -----------------------------------------------------------------------------
package stream_transpose_pkg;

    localparam logic MODE_TRANSPOSE = 1'b0;
    localparam logic MODE_BYPASS    = 1'b1;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/transpose_bank.sv
// -----------------------------------------------------------------------------
// transpose_bank
//
// One N x N element buffer of the ping-pong pair. Rows are written one per
// cycle; reads are combinational and return either a column (transpose) or a
// row (bypass) selected by rd_idx.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset (clears storage)
//   we                write strobe for one row
//   wr_row            row index to write
//   wr_data           packed row, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_mode           MODE_TRANSPOSE: column rd_idx; MODE_BYPASS: row rd_idx
//   rd_idx            column/row index to read
//   rd_data           packed read vector, same lane packing as wr_data
// -----------------------------------------------------------------------------
module transpose_bank
    import stream_transpose_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 4,
    parameter int CNT_W      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [CNT_W-1:0]        wr_row,
    input  logic [N*DATA_WIDTH-1:0] wr_data,
    input  logic                    rd_mode,
    input  logic [CNT_W-1:0]        rd_idx,
    output logic [N*DATA_WIDTH-1:0] rd_data
);

    // mem[row][lane]
    logic [DATA_WIDTH-1:0] mem [N][N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (we) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_row][c] <= wr_data[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            case (rd_mode)
                MODE_TRANSPOSE: rd_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = mem[i][rd_idx];
                MODE_BYPASS:    rd_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = mem[rd_idx][i];
                default:        rd_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = '0;
            endcase
        end
    end

endmodule

// File: rtl/stream_transpose_pp.sv
// -----------------------------------------------------------------------------
// stream_transpose_pp
//
// Streaming N x N matrix transpose with two ping-pong banks. One N-lane row
// is accepted per transfer; one N-lane column (or the original row, in
// bypass mode) is emitted per transfer. While one bank drains, the other
// fills, so rows and columns both move at full rate.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset; clears all state and storage
//   clk_en     clock enable; low freezes every register
//   mode       0 transpose / 1 bypass, latched on the row-0 transfer
//   in_valid   row valid
//   in_ready   row accepted when in_valid & in_ready & clk_en
//   in_data    packed row, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  output vector valid
//   out_ready  downstream accepts when out_valid & out_ready & clk_en
//   out_data   packed column (or row in bypass)
//   out_first  first vector of a matrix
//   out_last   last vector of a matrix
//
// All outputs are combinational decodes of registered state.
// -----------------------------------------------------------------------------
module stream_transpose_pp
    import stream_transpose_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*DATA_WIDTH-1:0] out_data,
    output logic                    out_first,
    output logic                    out_last
);

    localparam int               CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    logic [1:0]       full;
    logic [1:0]       bank_mode;
    logic             wr_bank;
    logic             rd_bank;
    logic [CNT_W-1:0] row_cnt;
    logic [CNT_W-1:0] col_cnt;

    logic             wr_fire;
    logic             rd_fire;
    logic [N*DATA_WIDTH-1:0] bank_rd [2];

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_fire   = in_valid && in_ready && clk_en;
    assign rd_fire   = out_valid && out_ready && clk_en;

    assign out_data  = bank_rd[rd_bank];
    assign out_first = out_valid && (col_cnt == '0);
    assign out_last  = out_valid && (col_cnt == LAST);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        transpose_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .N          (N),
            .CNT_W      (CNT_W)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .we      (wr_fire && (wr_bank == 1'(b))),
            .wr_row  (row_cnt),
            .wr_data (in_data),
            .rd_mode (bank_mode[b]),
            .rd_idx  (col_cnt),
            .rd_data (bank_rd[b])
        );
    end

    // Write and read sides touch different full bits: a write needs its bank
    // empty, a read needs its bank full, so they never collide on one index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full      <= '0;
            bank_mode <= {2{MODE_TRANSPOSE}};
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            row_cnt   <= '0;
            col_cnt   <= '0;
        end else begin
            if (wr_fire) begin
                if (row_cnt == '0) begin
                    bank_mode[wr_bank] <= mode;
                end
                if (row_cnt == LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    row_cnt       <= '0;
                end else begin
                    row_cnt <= row_cnt + CNT_W'(1);
                end
            end
            if (rd_fire) begin
                if (col_cnt == LAST) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    col_cnt       <= '0;
                end else begin
                    col_cnt <= col_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
